button_event_decoder: RTL

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// Classifies presses of a debounced button into SHORT / DOUBLE / LONG events
// and presents them through a single-entry valid/ready holding register.
//
//   state  | meaning
//   IDLE   | released, waiting for a press edge
//   PRESS1 | first press in progress, timing toward a long press
//   GAP    | released after a short press, waiting for a second press
//   PRESS2 | second press in progress
//   HELD   | long press already reported, waiting for release
module button_event_decoder #(
  parameter int LONG_CYCLES   = 16,
  parameter int DCLICK_CYCLES = 8,
  parameter int IS_PULLUP     = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_btn,
  input  logic       i_evt_ready,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  output logic       o_pressed,
  output logic       o_evt_drop
);

  localparam int MAX_CYC = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC) + 1;
  localparam logic [TW-1:0] LONG_TC   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_TC = TW'(DCLICK_CYCLES - 1);

  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;
  localparam logic [1:0] EVT_LONG   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_HELD
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pressed_q, pressed_d;
  logic            prev_q, prev_d;
  logic            valid_q, valid_d;
  logic [1:0]      code_q, code_d;
  logic            drop_q, drop_d;

  logic            press_edge;
  logic            release_edge;
  logic            gen;
  logic [1:0]      gen_code;

  assign pressed_d    = i_btn ^ (IS_PULLUP != 0);
  assign prev_d       = pressed_q;
  assign press_edge   = pressed_q & ~prev_q;
  assign release_edge = ~pressed_q & prev_q;

  always_comb begin
    state_d  = state_q;
    gen      = 1'b0;
    gen_code = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (press_edge) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (release_edge) begin
          state_d = S_GAP;
        end else if (timer_q == LONG_TC) begin
          state_d  = S_HELD;
          gen      = 1'b1;
          gen_code = EVT_LONG;
        end
      end
      S_GAP: begin
        // A press landing on the timeout cycle still counts as a double click.
        if (press_edge) begin
          state_d = S_PRESS2;
        end else if (timer_q == DCLICK_TC) begin
          state_d  = S_IDLE;
          gen      = 1'b1;
          gen_code = EVT_SHORT;
        end
      end
      S_PRESS2: begin
        if (release_edge) begin
          state_d  = S_IDLE;
          gen      = 1'b1;
          gen_code = EVT_DOUBLE;
        end else if (timer_q == LONG_TC) begin
          state_d  = S_HELD;
          gen      = 1'b1;
          gen_code = EVT_DOUBLE;
        end
      end
      S_HELD: begin
        if (release_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_PRESS1 || state_q == S_GAP || state_q == S_PRESS2) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Holding register: a new event may replace one being accepted this cycle.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    drop_d  = 1'b0;
    if (valid_q && i_evt_ready) begin
      valid_d = 1'b0;
      code_d  = 2'b00;
    end
    if (gen) begin
      if (!valid_q || i_evt_ready) begin
        valid_d = 1'b1;
        code_d  = gen_code;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      pressed_q <= 1'b0;
      prev_q    <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= 2'b00;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pressed_q <= pressed_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      drop_q    <= drop_d;
    end
  end

  assign o_evt_valid = valid_q;
  assign o_evt_code  = code_q;
  assign o_pressed   = pressed_q;
  assign o_evt_drop  = drop_q;

endmodule
